// File: rtl/frame_pkg.sv
// Shared constants and FSM encoding for the frame flusher and its raster counter.
package frame_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 6;
    localparam int COORD_W  = 8;
    localparam int VGA_Y_W  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/frame_flusher_if.sv
// Bus between the frame flusher, the combinational decoders and the VGA adapter.
//
// Control handshake: start is a level or pulse looked at only while the
// flusher is idle; once accepted, busy rises on the next cycle and stays high
// for the whole sweep plus the drain cycle; done is a single-cycle pulse after
// the last plot. start seen while busy or during done is ignored.
// Decoder path: flush_x/flush_y go out, layer_enable/layer_colour must come
// back combinationally within the same cycle.
// VGA path: vga_plot is a write strobe; vga_x/vga_y/vga_colour are valid
// whenever vga_plot is high. There is no back-pressure.
interface frame_flusher_if;
    import frame_pkg::*;

    logic                start;
    logic                busy;
    logic                done;
    logic [COORD_W-1:0]  flush_x;
    logic [COORD_W-1:0]  flush_y;
    logic                layer_enable;
    logic [COLOUR_W-1:0] layer_colour;
    logic [COORD_W-1:0]  vga_x;
    logic [VGA_Y_W-1:0]  vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        input  start, layer_enable, layer_colour,
        output busy, done, flush_x, flush_y,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        output start, layer_enable, layer_colour,
        input  busy, done, flush_x, flush_y,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/frame_flusher_raster_counter.sv
// x-fastest raster position counter; wraps to (0,0) after the bottom-right pixel.
module raster_counter
    import frame_pkg::*;
#(
    parameter int W = SCREEN_W,
    parameter int H = SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(H - 1);

    // Position register: step one pixel per advance, row wrap bumps y.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                if (y == Y_MAX) begin
                    y <= '0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/frame_flusher.sv
// Sweeps the whole frame through the decoders and streams one registered
// plot per pixel to the VGA adapter, painting unclaimed pixels with BG_COLOUR.
module frame_flusher #(
    parameter int                             SCREEN_W  = frame_pkg::SCREEN_W,
    parameter int                             SCREEN_H  = frame_pkg::SCREEN_H,
    parameter logic [frame_pkg::COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic              clk,
    input  logic              reset,
    frame_flusher_if.master   bus,
    output frame_pkg::state_t dbg_state
);

    frame_pkg::state_t             state;
    frame_pkg::state_t             state_next;
    logic [frame_pkg::COORD_W-1:0] pos_x;
    logic [frame_pkg::COORD_W-1:0] pos_y;
    logic                          pos_last;
    logic                          pos_clear;
    logic                          pos_advance;

    raster_counter #(
        .W (SCREEN_W),
        .H (SCREEN_H)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (pos_clear),
        .advance (pos_advance),
        .x       (pos_x),
        .y       (pos_y),
        .last    (pos_last)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= frame_pkg::IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control; the counter wraps itself to (0,0) on
    // the last SWEEP step, so DRAIN and IDLE already present the origin.
    always_comb begin
        state_next  = state;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        case (state)
            frame_pkg::IDLE: begin
                pos_clear = 1'b1;
                if (bus.start) begin
                    state_next = frame_pkg::SWEEP;
                end
            end
            frame_pkg::SWEEP: begin
                pos_advance = 1'b1;
                if (pos_last) begin
                    state_next = frame_pkg::DRAIN;
                end
            end
            frame_pkg::DRAIN: state_next = frame_pkg::DONE;
            frame_pkg::DONE:  state_next = frame_pkg::IDLE;
            default:          state_next = frame_pkg::IDLE;
        endcase
    end

    // Output register: captures this cycle's coordinate and decoder answer,
    // so each plot appears one cycle after its pixel was presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
        end else begin
            bus.vga_x      <= pos_x;
            bus.vga_y      <= pos_y[frame_pkg::VGA_Y_W-1:0];
            bus.vga_colour <= bus.layer_enable ? bus.layer_colour : BG_COLOUR;
            bus.vga_plot   <= (state == frame_pkg::SWEEP);
        end
    end

    assign bus.flush_x = pos_x;
    assign bus.flush_y = pos_y;
    assign bus.busy    = (state == frame_pkg::SWEEP) || (state == frame_pkg::DRAIN);
    assign bus.done    = (state == frame_pkg::DONE);
    assign dbg_state   = state;

endmodule

// File: tb/tb_frame_flusher.sv
// Bench for frame_flusher: timing checkpoints, full-frame plot scoreboard,
// back-to-back frames, mid-sweep reset and a non-zero background instance.
module tb_frame_flusher;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   mode = 0;
    int   white_cnt = 0;
    int   dec_idx;

    logic       rnd_en [NP];
    logic [5:0] rnd_col[NP];
    logic [20:0] exp_q[$];

    frame_pkg::state_t dut_state;
    frame_pkg::state_t bg_state;

    frame_flusher_if bus ();
    frame_flusher_if bus_bg ();

    frame_flusher dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dut_state)
    );

    frame_flusher #(.BG_COLOUR(6'b000011)) dut_bg (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_bg),
        .dbg_state (bg_state)
    );

    always #5 clk = ~clk;

    assign bus_bg.start        = bus.start;
    assign bus_bg.layer_enable = 1'b0;
    assign bus_bg.layer_colour = 6'b101010;

    // Decoder stubs: 0 = nobody claims, 1 = white at (3..6,0), 2 = random map.
    always_comb begin
        bus.layer_enable = 1'b0;
        bus.layer_colour = 6'h2A;
        dec_idx = 0;
        if (mode == 1) begin
            if (bus.flush_y == 8'd0 && bus.flush_x >= 8'd3 && bus.flush_x <= 8'd6) begin
                bus.layer_enable = 1'b1;
                bus.layer_colour = 6'h3F;
            end
        end else if (mode == 2) begin
            if (bus.flush_x < 8'(W) && bus.flush_y < 8'(H)) begin
                dec_idx = int'(bus.flush_y) * W + int'(bus.flush_x);
                bus.layer_enable = rnd_en[dec_idx];
                bus.layer_colour = rnd_col[dec_idx];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the whole frame in raster order, colour chosen by the stub rule.
    task automatic push_frame(input int m);
        logic       en;
        logic [5:0] col;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                en  = 1'b0;
                col = 6'h00;
                if (m == 1 && y == 0 && x >= 3 && x <= 6) begin
                    en  = 1'b1;
                    col = 6'h3F;
                end else if (m == 2) begin
                    en  = rnd_en[y * W + x];
                    col = rnd_col[y * W + x];
                end
                exp_q.push_back({8'(x), 7'(y), (en ? col : 6'b000000)});
            end
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < limit);
        if (!bus.done) chk("done_timeout", 32'(n), 32'(limit + 1));
    endtask

    // Scoreboard: every plot must match the next expected pixel.
    always @(negedge clk) begin
        if (bus.vga_plot) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL plot_extra: got x=%0d y=%0d c=%0h expected no plot",
                         bus.vga_x, bus.vga_y, bus.vga_colour);
            end else begin
                chk("plot", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(exp_q.pop_front()));
            end
            if (bus.vga_colour == 6'h3F) white_cnt++;
        end
        if (bus_bg.vga_plot) chk("bg_colour", 32'(bus_bg.vga_colour), 32'h03);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         cyc;
        logic [7:0] fx;
        logic [7:0] fy;
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] vx;
        logic [6:0] vy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ti;
        int n;
        int done_seen;

        tbl[0] = '{1,     8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 8'd0,   7'd0};
        tbl[1] = '{2,     8'd1,   8'd0,   1'b1, 1'b0, 1'b1, 8'd0,   7'd0};
        tbl[2] = '{3,     8'd2,   8'd0,   1'b1, 1'b0, 1'b1, 8'd1,   7'd0};
        tbl[3] = '{160,   8'd159, 8'd0,   1'b1, 1'b0, 1'b1, 8'd158, 7'd0};
        tbl[4] = '{161,   8'd0,   8'd1,   1'b1, 1'b0, 1'b1, 8'd159, 7'd0};
        tbl[5] = '{162,   8'd1,   8'd1,   1'b1, 1'b0, 1'b1, 8'd0,   7'd1};
        tbl[6] = '{19200, 8'd159, 8'd119, 1'b1, 1'b0, 1'b1, 8'd158, 7'd119};
        tbl[7] = '{19201, 8'd0,   8'd0,   1'b1, 1'b0, 1'b1, 8'd159, 7'd119};
        tbl[8] = '{19202, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 8'd0,   7'd0};
        tbl[9] = '{19203, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 8'd0,   7'd0};

        for (int i = 0; i < NP; i++) begin
            rnd_en[i]  = ($urandom_range(0, 3) == 0);
            rnd_col[i] = 6'($urandom);
        end

        // Reset state.
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dut_state), 32'(frame_pkg::IDLE));
        chk("rst_plot", 32'(bus.vga_plot), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_flush", 32'({bus.flush_x, bus.flush_y}), 32'd0);
        chk("rst_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Frame 1: start pulse, no decoder claims anything.
        mode = 0;
        push_frame(0);
        bus.start = 1'b1;
        ti = 0;
        for (int k = 1; k <= 19203; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (ti < 10 && tbl[ti].cyc == k) begin
                chk($sformatf("t%0d_flush", k), 32'({bus.flush_x, bus.flush_y}), 32'({tbl[ti].fx, tbl[ti].fy}));
                chk($sformatf("t%0d_busy", k), 32'(bus.busy), 32'(tbl[ti].busy));
                chk($sformatf("t%0d_done", k), 32'(bus.done), 32'(tbl[ti].done));
                chk($sformatf("t%0d_plot", k), 32'(bus.vga_plot), 32'(tbl[ti].plot));
                chk($sformatf("t%0d_vxy", k), 32'({bus.vga_x, bus.vga_y}), 32'({tbl[ti].vx, tbl[ti].vy}));
                ti++;
            end
        end
        chk("f1_all_plotted", 32'(exp_q.size()), 32'd0);

        // Frames 2 and 3 with start held high: stub decoder, then random map.
        mode = 1;
        white_cnt = 0;
        push_frame(1);
        bus.start = 1'b1;
        wait_done(20000, n);
        chk("f2_done_cycle", 32'(n), 32'd19202);
        chk("f2_all_plotted", 32'(exp_q.size()), 32'd0);
        chk("f2_white_plots", 32'(white_cnt), 32'd4);
        mode = 2;
        push_frame(2);
        @(negedge clk);
        chk("f3_idle_state", 32'(dut_state), 32'(frame_pkg::IDLE));
        chk("f3_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("f3_sweep_busy", 32'(bus.busy), 32'd1);
        chk("f3_sweep_origin", 32'({bus.flush_x, bus.flush_y}), 32'd0);
        @(negedge clk);
        chk("f3_first_plot", 32'(bus.vga_plot), 32'd1);
        wait_done(20000, n);
        chk("f3_done_cycle", 32'(n), 32'd19200);
        chk("f3_all_plotted", 32'(exp_q.size()), 32'd0);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("f3_no_restart_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("f3_no_restart_state", 32'(dut_state), 32'(frame_pkg::IDLE));

        // Frame 4: reset at cycle 5000 mid-sweep.
        mode = 0;
        push_frame(0);
        bus.start = 1'b1;
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_plot", 32'(bus.vga_plot), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_state", 32'(dut_state), 32'(frame_pkg::IDLE));
        chk("mid_rst_bg_plot", 32'(bus_bg.vga_plot), 32'd0);
        exp_q.delete();
        done_seen = int'(bus.done);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            done_seen += int'(bus.done) + int'(bus.busy);
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);

        // Restart after the reset must begin at the origin.
        push_frame(0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 32'd1);
        chk("restart_origin", 32'({bus.flush_x, bus.flush_y}), 32'd0);
        @(negedge clk);
        chk("restart_first_plot", 32'({bus.vga_plot, bus.vga_x, bus.vga_y}), 32'({1'b1, 8'd0, 7'd0}));
        repeat (298) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_flusher.md
# frame_flusher

Raster sweep controller for the glyph and sprite decoders. On `start` it walks `flush_x`/`flush_y` across the whole 160×120 frame, one pixel per clock, and drives those coordinates into every combinational decoder. It samples the OR-combined `layer_enable`/`layer_colour` the decoders return and emits one registered plot per pixel to the VGA adapter. Pixels no decoder claims are painted with the background colour.

## Interface
Parameters:
- `SCREEN_W`, default 160: pixels per row.
- `SCREEN_H`, default 120: rows per frame.
- `BG_COLOUR`, default 6'b000000: colour plotted where no layer is enabled.

Ports:
- `clk`  in  1: single system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: level or pulse; sampled only in IDLE.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse after the last plot.
- `flush_x`  out  8: current sweep column, to decoders.
- `flush_y`  out  8: current sweep row, to decoders.
- `layer_enable`  in  1: OR of all decoder enables for (`flush_x`, `flush_y`).
- `layer_colour`  in  6: colour of the winning decoder (priority resolved upstream).
- `vga_x`  out  8: plot column.
- `vga_y`  out  7: plot row.
- `vga_colour`  out  6: plot colour, RRGGBB.
- `vga_plot`  out  1: write strobe to the VGA adapter.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - `flush_x` = `flush_y` = 0; `busy` = 0.
  - `start` = 1 → SWEEP.
- SWEEP:
  - Each cycle presents (`flush_x`, `flush_y`) and advances x-fastest.
  - At `flush_x` = `SCREEN_W`−1, x wraps to 0 and y increments.
  - On the cycle presenting (`SCREEN_W`−1, `SCREEN_H`−1) → DRAIN; counters wrap to (0,0).
- DRAIN: one cycle, lets the last registered pixel plot. → DONE.
- DONE: `done` = 1 for one cycle. → IDLE.
- Output register, loaded every cycle:
  - `vga_x`/`vga_y` ← previous `flush_x`/`flush_y[6:0]`.
  - `vga_colour` ← `layer_enable` ? `layer_colour` : `BG_COLOUR`.
  - `vga_plot` ← (state == SWEEP).
- `start` while `busy` is ignored; there is no restart mid-frame.
- Coordinates never exceed `SCREEN_W`−1 / `SCREEN_H`−1. Decoders handle their own 8-bit subtraction wrap.

## Timing
- Reset values:
  - state = IDLE.
  - `flush_x`, `flush_y`, `vga_x`, `vga_y`, `vga_colour` = 0.
  - `vga_plot`, `busy`, `done` = 0.
- Reset during SWEEP or DRAIN:
  - Next cycle: IDLE, `vga_plot` = 0, no `done` pulse.
  - A subsequent `start` begins again at (0,0).
- Latency:
  - `start` sampled at cycle 0 → SWEEP at cycle 1, presenting (0,0).
  - First `vga_plot` at cycle 2.
- Plot stream:
  - Exactly `SCREEN_W`×`SCREEN_H` (19200) consecutive `vga_plot` cycles, no gaps.
  - Last plot (159,119) at cycle 19201.
  - `done` at cycle 19202.
  - `busy` high for cycles 1–19201.
- Decoder path (`flush_*` → `layer_*`) is purely combinational and must close within one clock.

## Structure
- Shared package `frame_pkg`:
  - `SCREEN_W`, `SCREEN_H`.
  - `COLOUR_W` = 6, `COORD_W` = 8, `VGA_Y_W` = 7.
  - FSM state enum.
- One sub-module, `raster_counter`:
  - Inputs: `clk`, `reset`, `clear`, `advance`.
  - Outputs: x, y, `last` (high at bottom-right).
  - Reused later by the sprite-erase path.
- Top-level `frame_flusher` holds the FSM and the output register.

## Test plan
- Reset, then `start` pulse at cycle 0 with `layer_enable` = 0:
  - 19200 plots, all `vga_colour` = 0.
  - First plot (0,0) at cycle 2, last (159,119) at cycle 19201.
  - `done` pulse at cycle 19202.
- Stub decoder enabling only (3..6, 0) with colour 6'b111111:
  - Exactly 4 plots carry 6'b111111, at `vga_x` 3–6, `vga_y` 0; all others carry `BG_COLOUR`.
- Row wrap: observe the `flush_x` = 159 → 0 transition.
  - Same cycle, `flush_y` increments.
  - Next plot after (159,0) is (0,1).
- `start` held high throughout:
  - No extra plots during the sweep.
  - A second frame begins at the cycle after `done` (IDLE samples `start` = 1).
- Assert `reset` at cycle 5000 mid-sweep:
  - `vga_plot` = 0 and `busy` = 0 on the next cycle; no `done`.
  - A later `start` restarts from (0,0).
- `BG_COLOUR` = 6'b000011, `layer_enable` = 0:
  - Every plot colour = 6'b000011.
